integer_issue_queue: RTL and testbench

- In-order-of-age issue queue (reservation station) feeding the single-cycle integer ALU.
- Accepts decoded integer ops from dispatch, holding operands as values or pending 5-bit tags.
- Captures results broadcast on the common data bus (CDB) to wake waiting operands.
- Each cycle, sends the oldest fully-ready op to the ALU through a registered issue stage, packed in the ALU's 73-bit `{aluop, rd, op1, op2}` format.

---
 rtl/integer_issue_queue.sv | 145 ++++++++++++++
 tb/tb_integer_issue_queue.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/integer_issue_queue.sv
// Integer issue queue: age-ordered compacting reservation station with CDB
// wakeup, dispatch bypass and a registered issue stage feeding the ALU.
module integer_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       dispatch_valid,
  output logic                       dispatch_ready,
  input  logic [3:0]                 dispatch_aluop,
  input  logic [4:0]                 dispatch_rd,
  input  logic [31:0]                dispatch_op1,
  input  logic [31:0]                dispatch_op2,
  input  logic                       dispatch_op1_rdy,
  input  logic                       dispatch_op2_rdy,
  input  logic [TAG_W-1:0]           dispatch_op1_tag,
  input  logic [TAG_W-1:0]           dispatch_op2_tag,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [31:0]                cdb_value,
  output logic                       issue_valid,
  output logic [72:0]                issue_rs,
  input  logic                       issue_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [3:0]       aluop;
    logic [4:0]       rd;
    logic [31:0]      v1;
    logic             r1;
    logic [TAG_W-1:0] t1;
    logic [31:0]      v2;
    logic             r2;
    logic [TAG_W-1:0] t2;
  } entry_t;

  entry_t          q     [DEPTH];
  entry_t          q_nxt [DEPTH];
  entry_t          ins;
  logic [CW-1:0]   count_nxt;
  logic [CW-1:0]   tail;
  logic [IW-1:0]   cand;
  logic            has_cand;
  logic            take;
  logic            accept;
  logic            wake_en;
  logic            byp1;
  logic            byp2;

  // A stored operand that is still waiting captures a matching broadcast.
  function automatic entry_t wake(entry_t e, logic en, logic [TAG_W-1:0] tag,
                                  logic [31:0] val);
    entry_t r;
    r = e;
    if (en && !e.r1 && e.t1 == tag) begin
      r.v1 = val;
      r.r1 = 1'b1;
    end
    if (en && !e.r2 && e.t2 == tag) begin
      r.v2 = val;
      r.r2 = 1'b1;
    end
    return r;
  endfunction

  assign dispatch_ready = (count != CW'(DEPTH));
  assign wake_en        = cdb_valid && !flush;
  assign byp1           = !dispatch_op1_rdy && cdb_valid && (cdb_tag == dispatch_op1_tag);
  assign byp2           = !dispatch_op2_rdy && cdb_valid && (cdb_tag == dispatch_op2_tag);

  // Incoming entry, with same-cycle CDB bypass folded in.
  always_comb begin
    ins.aluop = dispatch_aluop;
    ins.rd    = dispatch_rd;
    ins.v1    = byp1 ? cdb_value : dispatch_op1;
    ins.r1    = dispatch_op1_rdy || byp1;
    ins.t1    = dispatch_op1_tag;
    ins.v2    = byp2 ? cdb_value : dispatch_op2;
    ins.r2    = dispatch_op2_rdy || byp2;
    ins.t2    = dispatch_op2_tag;
  end

  // Select the oldest entry whose operands were both ready before this edge.
  always_comb begin
    has_cand = 1'b0;
    cand     = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (CW'(i) < count && q[i].r1 && q[i].r2) begin
        has_cand = 1'b1;
        cand     = IW'(i);
      end
    end
  end

  // Compaction, wakeup in the post-shift position, and tail insert.
  always_comb begin
    take      = has_cand && (!issue_valid || issue_ready);
    accept    = dispatch_valid && dispatch_ready && !flush;
    tail      = count - CW'(take);
    count_nxt = flush ? '0 : (count - CW'(take) + CW'(accept));
    for (int i = 0; i < DEPTH; i++) begin
      // Slot DEPTH-1 wraps to a stale source; it is beyond the new count or
      // overwritten by the tail insert, so the value is never used.
      if (take && IW'(i) >= cand)
        q_nxt[i] = wake(q[(i + 1) % DEPTH], wake_en, cdb_tag, cdb_value);
      else
        q_nxt[i] = wake(q[i], wake_en, cdb_tag, cdb_value);
      if (accept && tail == CW'(i))
        q_nxt[i] = ins;
    end
  end

  // Queue storage and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= '0;
    end else begin
      count <= count_nxt;
      q     <= q_nxt;
    end
  end

  // Issue register: loads when free or being consumed, holds under backpressure.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_valid <= 1'b0;
      issue_rs    <= '0;
    end else if (flush) begin
      issue_valid <= 1'b0;
    end else if (take) begin
      issue_valid <= 1'b1;
      issue_rs    <= {q[cand].aluop, q[cand].rd, q[cand].v1, q[cand].v2};
    end else if (issue_ready) begin
      issue_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_integer_issue_queue.sv
// Scoreboard bench for integer_issue_queue: an op-list reference model
// predicts issues; a negedge monitor checks every ALU handshake.
module tb_integer_issue_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush;
  logic        dispatch_valid, dispatch_ready;
  logic [3:0]  dispatch_aluop;
  logic [4:0]  dispatch_rd;
  logic [31:0] dispatch_op1, dispatch_op2;
  logic        dispatch_op1_rdy, dispatch_op2_rdy;
  logic [4:0]  dispatch_op1_tag, dispatch_op2_tag;
  logic        cdb_valid;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic        issue_valid, issue_ready;
  logic [72:0] issue_rs;
  logic [2:0]  count;

  integer_issue_queue #(.DEPTH(DEPTH), .TAG_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_aluop(dispatch_aluop), .dispatch_rd(dispatch_rd),
    .dispatch_op1(dispatch_op1), .dispatch_op2(dispatch_op2),
    .dispatch_op1_rdy(dispatch_op1_rdy), .dispatch_op2_rdy(dispatch_op2_rdy),
    .dispatch_op1_tag(dispatch_op1_tag), .dispatch_op2_tag(dispatch_op2_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_ready(issue_ready),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  aluop;
    logic [4:0]  rd;
    logic [31:0] v1, v2;
    logic        r1, r2;
    logic [4:0]  t1, t2;
  } op_t;

  op_t         mq[$];
  logic [72:0] exp_q[$];
  logic        m_iv = 1'b0;
  logic [72:0] m_rs = '0;
  int          vectors = 0;
  int          errors = 0;

  task automatic cmp(string name, logic [72:0] act, logic [72:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every ALU handshake must deliver the next op the model issued.
  always @(negedge clk) begin
    if (reset && issue_valid && issue_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_issue: got %h expected nothing", issue_rs);
      end else begin
        logic [72:0] e;
        e = exp_q.pop_front();
        if (e !== issue_rs) begin
          errors++;
          $display("FAIL issue_order: got %h expected %h", issue_rs, e);
        end
      end
    end
  end

  // Reference: ordered op list; oldest ready op leaves, then broadcasts land,
  // then the new op joins the back.
  task automatic model_step();
    int  idx;
    bit  acc, take;
    op_t n;
    idx = -1;
    acc = dispatch_valid && (mq.size() != DEPTH) && !flush;
    for (int i = 0; i < mq.size(); i++)
      if (idx < 0 && mq[i].r1 && mq[i].r2) idx = i;
    if (flush) begin
      if (m_iv) void'(exp_q.pop_back());
      mq.delete();
      m_iv = 1'b0;
      return;
    end
    take = (idx >= 0) && (!m_iv || issue_ready);
    if (take) begin
      n = mq[idx];
      mq.delete(idx);
      m_iv = 1'b1;
      m_rs = {n.aluop, n.rd, n.v1, n.v2};
      exp_q.push_back(m_rs);
    end else if (issue_ready) begin
      m_iv = 1'b0;
    end
    if (cdb_valid) begin
      foreach (mq[i]) begin
        if (!mq[i].r1 && mq[i].t1 == cdb_tag) begin mq[i].v1 = cdb_value; mq[i].r1 = 1'b1; end
        if (!mq[i].r2 && mq[i].t2 == cdb_tag) begin mq[i].v2 = cdb_value; mq[i].r2 = 1'b1; end
      end
    end
    if (acc) begin
      n.aluop = dispatch_aluop;
      n.rd    = dispatch_rd;
      n.t1    = dispatch_op1_tag;
      n.t2    = dispatch_op2_tag;
      n.r1    = dispatch_op1_rdy || (cdb_valid && cdb_tag == dispatch_op1_tag);
      n.r2    = dispatch_op2_rdy || (cdb_valid && cdb_tag == dispatch_op2_tag);
      n.v1    = dispatch_op1_rdy ? dispatch_op1 : cdb_value;
      n.v2    = dispatch_op2_rdy ? dispatch_op2 : cdb_value;
      mq.push_back(n);
    end
  endtask

  task automatic check();
    cmp("count", 73'(count), 73'(mq.size()));
    cmp("issue_valid", 73'(issue_valid), 73'(m_iv));
    cmp("dispatch_ready", 73'(dispatch_ready), 73'(mq.size() != DEPTH));
    if (m_iv) cmp("issue_rs", issue_rs, m_rs);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check();
  endtask

  task automatic idle();
    flush = 1'b0; dispatch_valid = 1'b0; cdb_valid = 1'b0; issue_ready = 1'b1;
    dispatch_aluop = '0; dispatch_rd = '0; dispatch_op1 = '0; dispatch_op2 = '0;
    dispatch_op1_rdy = 1'b1; dispatch_op2_rdy = 1'b1;
    dispatch_op1_tag = '0; dispatch_op2_tag = '0; cdb_tag = '0; cdb_value = '0;
  endtask

  task automatic disp(input logic [3:0] op, input logic [4:0] rd,
                      input logic [31:0] a, input logic ar, input logic [4:0] at,
                      input logic [31:0] b, input logic br, input logic [4:0] bt);
    dispatch_valid = 1'b1; dispatch_aluop = op; dispatch_rd = rd;
    dispatch_op1 = a; dispatch_op1_rdy = ar; dispatch_op1_tag = at;
    dispatch_op2 = b; dispatch_op2_rdy = br; dispatch_op2_tag = bt;
  endtask

  task automatic cdb(input logic [4:0] t, input logic [31:0] v);
    cdb_valid = 1'b1; cdb_tag = t; cdb_value = v;
  endtask

  initial begin
    logic [72:0] want;
    idle();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    cmp("reset_issue_rs", issue_rs, '0);
    check();

    // Basic issue: visible two cycles after dispatch.
    idle(); disp(4'b0000, 5'd3, 32'd5, 1, 0, 32'd7, 1, 0); step();
    idle(); step();
    want = {4'b0000, 5'd3, 32'd5, 32'd7};
    cmp("basic_issue_rs", issue_rs, want);
    cmp("basic_issue_valid", 73'(issue_valid), 73'(1));
    idle(); step();

    // Wakeup via CDB, then same-cycle bypass.
    idle(); disp(4'b0001, 5'd4, 32'd10, 1, 0, 32'd0, 0, 5'd9); step();
    repeat (3) begin idle(); step(); end
    idle(); cdb(5'd9, 32'd2); step();
    repeat (2) begin idle(); step(); end
    idle(); disp(4'b0001, 5'd6, 32'd11, 1, 0, 32'd0, 0, 5'd9); cdb(5'd9, 32'd2); step();
    repeat (2) begin idle(); step(); end

    // Age order: A waits on tag 4, B and C ready.
    idle(); disp(4'd2, 5'd1, 32'd1, 0, 5'd4, 32'd1, 1, 0); step();
    idle(); disp(4'd3, 5'd2, 32'd2, 1, 0, 32'd2, 1, 0); step();
    idle(); disp(4'd4, 5'd3, 32'd3, 1, 0, 32'd3, 1, 0); step();
    repeat (2) begin idle(); step(); end
    idle(); cdb(5'd4, 32'hAA); step();
    repeat (3) begin idle(); step(); end

    // Full and backpressure.
    for (int i = 0; i < 6; i++) begin
      idle(); issue_ready = 1'b0;
      disp(4'(i), 5'(i), 32'(i), 1, 0, 32'(i + 100), 1, 0); step();
    end
    repeat (10) begin idle(); issue_ready = 1'b0; step(); end
    repeat (7) begin idle(); step(); end

    // Flush with queued ops and a held issue register, dispatch in same cycle.
    for (int i = 0; i < 4; i++) begin
      idle(); issue_ready = 1'b0;
      disp(4'(i + 8), 5'(i), 32'(i), 1, 0, 32'(i), 1, 0); step();
    end
    idle(); issue_ready = 1'b0; step();
    idle(); issue_ready = 1'b0; flush = 1'b1;
    disp(4'd15, 5'd31, 32'd9, 1, 0, 32'd9, 1, 0); step();
    cmp("flush_count", 73'(count), 73'(0));
    repeat (3) begin idle(); step(); end

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      idle();
      if ($urandom_range(0, 9) < 6)
        disp(4'($urandom), 5'($urandom), $urandom, 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 7)));
      if ($urandom_range(0, 9) < 4) cdb(5'($urandom_range(0, 7)), $urandom);
      issue_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 99) < 3) begin flush = 1'b1; issue_ready = 1'b0; end
      step();
    end

    // Asynchronous reset with a full queue, between clock edges.
    for (int i = 0; i < 6; i++) begin
      idle(); issue_ready = 1'b0;
      disp(4'd5, 5'(i), 32'(i), 1, 0, 32'(i), 1, 0); step();
    end
    idle(); issue_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    cmp("async_count", 73'(count), 73'(0));
    cmp("async_issue_valid", 73'(issue_valid), 73'(0));
    cmp("async_issue_rs", issue_rs, '0);
    cmp("async_dispatch_ready", 73'(dispatch_ready), 73'(1));
    mq.delete(); exp_q.delete(); m_iv = 1'b0; m_rs = '0;
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1; check();
    repeat (3) begin idle(); step(); end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
